// File: rtl/booth4_seq_mult_ctrl_pkg.sv
// Shared widths, iteration count and FSM encoding for the radix-4 Booth
// sequential multiplier and its partial-product decoder.
package booth4_seq_mult_ctrl_pkg;

  localparam int OP_W     = 16;
  localparam int CODE_W   = 17;
  localparam int PP_W     = 18;
  localparam int PROD_W   = 32;
  localparam int ITER_NUM = 8;
  localparam int CNT_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The decoder emits its MSB as an inverted sign; flip it back to get
  // the ordinary two's-complement partial product.
  function automatic logic signed [PP_W-1:0] pp_restore(input logic [PP_W-1:0] pp_enc);
    return {~pp_enc[PP_W-1], pp_enc[PP_W-2:0]};
  endfunction

endpackage

// File: rtl/booth4_seq_mult_ctrl_pp_decoder.sv
// Radix-4 Booth partial-product selector: picks 0, +-A or +-2A from a 3-bit
// code and returns it with an inverted sign bit.
module booth2_pp_decoder
  import booth4_seq_mult_ctrl_pkg::*;
(
  input  logic        [2:0]        code,
  input  logic signed [OP_W-1:0]   A,
  input  logic signed [CODE_W-1:0] inversed_A,
  output logic        [PP_W-1:0]   pp_out
);

  logic signed [PP_W-1:0] pp;

  always_comb begin
    pp = '0;
    unique case (code)
      3'b001, 3'b010: pp = {{2{A[OP_W-1]}}, A};
      3'b011:         pp = {A[OP_W-1], A, 1'b0};
      3'b100:         pp = {inversed_A, 1'b0};
      3'b101, 3'b110: pp = {inversed_A[CODE_W-1], inversed_A};
      default:        pp = '0;
    endcase
  end

  assign pp_out = {~pp[PP_W-1], pp[PP_W-2:0]};

endmodule

// File: rtl/booth4_seq_mult_ctrl.sv
// Sequential 16x16 signed radix-4 Booth multiplier: one Booth digit per RUN
// cycle, fixed eight iterations, valid/ready handshakes on both sides.
module booth4_seq_mult_ctrl
  import booth4_seq_mult_ctrl_pkg::*;
(
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic        [OP_W-1:0]   a,
  input  logic        [OP_W-1:0]   b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [PROD_W-1:0] product,
  output logic                     busy
);

  state_e                    state_q, state_d;
  logic signed [OP_W-1:0]    a_q, a_d;
  logic        [CODE_W-1:0]  code_q, code_d;
  logic signed [PROD_W-1:0]  acc_q, acc_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d;

  logic signed [CODE_W-1:0]  neg_a;
  logic        [PP_W-1:0]    pp_enc;
  logic signed [PP_W-1:0]    pp_true;
  logic signed [PROD_W-1:0]  pp_ext;
  logic signed [PROD_W-1:0]  pp_shifted;

  // 17 bits so that negating -32768 yields an exact +32768.
  assign neg_a      = -$signed({a_q[OP_W-1], a_q});
  assign pp_true    = pp_restore(pp_enc);
  assign pp_ext     = {{(PROD_W-PP_W){pp_true[PP_W-1]}}, pp_true};
  assign pp_shifted = pp_ext <<< {cnt_q, 1'b0};

  booth2_pp_decoder u_pp_dec (
    .code       (code_q[2:0]),
    .A          (a_q),
    .inversed_A (neg_a),
    .pp_out     (pp_enc)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      code_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      code_q  <= code_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    code_d  = code_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_d = ST_RUN;
            a_d     = $signed(a);
            code_d  = {b, 1'b0};
            acc_d   = '0;
            cnt_d   = '0;
          end
        end
        ST_RUN: begin
          acc_d  = acc_q + pp_shifted;
          code_d = code_q >> 2;
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == CNT_W'(ITER_NUM - 1)) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign product   = acc_q;

endmodule
